mem_responder: RTL and testbench

//  Memory-side responder for the control unit's fetch/load/store requests in the multicycle CPU.

---
 rtl/cpu_defs_pkg.sv | 15 +
 rtl/mem_array.sv | 38 +++
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: word width, memory responder state encoding and the
// default memory geometry/timing that the control unit relies on for fetch timing.
package cpu_defs_pkg;

    localparam int WORD_W      = 32;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous DEPTH x WORD_W storage with write enable and a
// registered read port that is cleared by reset or by an explicit clr strobe.
module mem_array
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset so this maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the multicycle CPU (IDLE -> WAIT -> DONE).
// Optional misaligned-access detection is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_responder
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err,
    output logic [1:0]        state_dbg
);

    // Handshake: req is only looked at in IDLE; the requester keeps it up (or
    // re-issues it) until ack, which is a single-cycle pulse; nothing is queued.

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_t        state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              we_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              err_q;
    logic              access;
    logic              bad_align;

`ifdef MEM_MISALIGN_CHECK_EN
    logic mis_q;
    logic addr_unused;
    assign addr_unused = ^addr[31:AW+2];
    assign bad_align   = mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (state == IDLE && req) begin
            mis_q <= (addr[1:0] != 2'b00);
        end
    end
`else
    logic addr_unused;
    assign addr_unused = ^{addr[31:AW+2], addr[1:0]};
    assign bad_align   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err_q <= access && bad_align;
            if (state == IDLE && req) begin
                we_q    <= we;
                idx_q   <= addr[AW+1:2];
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        access   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = WAIT;
                    cnt_nx   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    access   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A flagged misaligned access touches no memory and forces rdata to zero.
    mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .reset (reset),
        .en    (access && !bad_align),
        .we    (we_q),
        .clr   (access && bad_align),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign ack       = (state == DONE);
    assign busy      = (state == WAIT);
    assign err       = err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, busy/reset corner sequences,
// then randomized traffic checked against an array-based reference model.
module tb_mem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack, busy, err;
    logic [1:0]  state_dbg;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .busy      (busy),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_rd;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
    } vec_t;
    vec_t tv[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // Behavioural view: word index is the byte address divided by 4, modulo DEPTH.
    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] er, output logic ee);
        int idx;
        idx = int'((a >> 2) % DEPTH);
        if (CHK && (a % 4) != 0) begin
            er = 32'h0;
            ee = 1'b1;
        end else begin
            ee = 1'b0;
            if (w) begin
                ref_mem[idx] = d;
                er = last_rd;
            end else begin
                er = ref_mem[idx];
            end
        end
        last_rd = er;
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic e, output logic got);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        lat = 0; got = 1'b0; rd = '0; e = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1; rd = rdata; e = err;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout addr=%h actual=no_ack required=ack", a);
        end else begin
            @(negedge clk);
            check("ack_one_cycle", {31'b0, ack}, 32'h0);
        end
    endtask

    task automatic run_one(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] er, rd, qv;
        logic ee, e, got;
        int lat;
        model_step(w, a, d, er, ee);
        exp_q.push_back(er);
        xact(w, a, d, lat, rd, e, got);
        qv = exp_q.pop_front();
        if (got) begin
            check("rand_latency", lat, LATENCY);
            check("rand_rdata", rd, qv);
            check("rand_err", {31'b0, e}, {31'b0, ee});
        end
    endtask

    initial begin
        int lat, acks;
        logic [31:0] rd, old;
        logic e, got;

        tv[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tv[1] = '{1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 1'b0};
        tv[2] = '{1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0};
        tv[3] = '{1'b0, 32'h0000_0000, 32'h0,        32'hA5A5_A5A5, 1'b0};
        tv[4] = '{1'b1, 32'h0000_0030, 32'h1111_1111, 32'hA5A5_A5A5, 1'b0};
        tv[5] = '{1'b1, 32'h0000_0031, 32'h2222_2222, CHK ? 32'h0 : 32'hA5A5_A5A5, CHK};
        tv[6] = '{1'b0, 32'h0000_0030, 32'h0,        CHK ? 32'h1111_1111 : 32'h2222_2222, 1'b0};
        tv[7] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, CHK ? 32'h1111_1111 : 32'h2222_2222, 1'b0};
        tv[8] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        32'hCAFE_F00D, 1'b0};
        tv[9] = '{1'b0, 32'h0000_0012, 32'h0,        CHK ? 32'h0 : 32'hDEAD_BEEF, CHK};

        // Reset held for two cycles
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_ack", {31'b0, ack}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        check("reset_state", {30'b0, state_dbg}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            xact(tv[i].w, tv[i].a, tv[i].d, lat, rd, e, got);
            if (got) begin
                check($sformatf("vec%0d_latency", i), lat, LATENCY);
                check($sformatf("vec%0d_rdata", i), rd, tv[i].er);
                check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, tv[i].ee});
            end
        end
        last_rd = tv[9].er;

        // Fill every word so the model knows the whole array
        for (int i = 0; i < DEPTH; i++) run_one(1'b1, 32'(i * 4), $urandom);

        // Write request raised while a read of the same word is in flight
        old = ref_mem[8];
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h20;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("busy_in_wait", {31'b0, busy}, 32'h1);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = ~old;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                check("busy_read_rdata", rdata, old);
            end
        end
        check("busy_ack_count", acks, 1);
        last_rd = old;
        run_one(1'b0, 32'h20, 32'h0);

        // Reset while a write is waiting: no commit, no ack
        old = ref_mem[12];
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h30;
        wdata = (old == 32'h1234_5678) ? 32'h8765_4321 : 32'h1234_5678;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("abort_ack_count", acks, 0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_rdata", rdata, 32'h0);
        last_rd = 32'h0;
        run_one(1'b0, 32'h30, 32'h0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_one(1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
